// File: rtl/fixed_mult_arbiter.sv
// Round-robin arbiter in front of one shared signed fixed-point multiplier (IDLE -> MULT -> HOLD).
// Define FIXED_MULT_SAT_EN to saturate rsp_p on overflow/underflow instead of truncating.
module fixed_mult_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned FRACT_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_p,
  output logic                       rsp_ovf,
  output logic                       rsp_unf,
  output logic [1:0]                 err_sticky,
  input  logic                       err_clr,
  output logic                       busy
);

  localparam int unsigned IdW   = $clog2(NUM_REQ);
  localparam int unsigned ProdW = 2 * WIDTH;
  localparam int unsigned Msb   = WIDTH - 1 + FRACT_BITS;

  typedef enum logic [1:0] {StIdle, StMult, StHold} state_e;

  state_e             state_q, state_d;
  logic [IdW-1:0]     last_grant_q;
  logic [IdW-1:0]     id_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   rsp_p_q;
  logic [IdW-1:0]     rsp_id_q;
  logic               ovf_q, unf_q;
  logic [1:0]         err_q, err_d;

  logic               gnt_found;
  logic [IdW-1:0]     gnt_id;
  logic [IdW-1:0]     idx;
  logic [WIDTH-1:0]   a_sel, b_sel;
  logic               grant;

  logic [ProdW-1:0]   a_ext, b_ext, prod;
  logic [ProdW-Msb-2:0] prod_hi;
  logic               ovf_d, unf_d;
  logic [WIDTH-1:0]   p_d;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IdW'((32'(last_grant_q) + 32'd1 + k) % NUM_REQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IdW'(i)) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign grant = (state_q == StIdle) && gnt_found && !rst;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_found) state_d = StMult;
      StMult:  state_d = StHold;
      StHold:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id;
    end
    busy      = (state_q != StIdle);
    rsp_valid = (state_q == StHold);
  end

  // Full-width signed product; bits above the result MSB must all match it to be in range.
  always_comb begin
    a_ext   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_ext   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod    = $signed(a_ext) * $signed(b_ext);
    prod_hi = prod[ProdW-1:Msb+1];
    ovf_d   = !prod[Msb] && (|prod_hi);
    unf_d   = prod[Msb] && !(&prod_hi);
`ifdef FIXED_MULT_SAT_EN
    if (ovf_d) begin
      p_d = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (unf_d) begin
      p_d = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      p_d = prod[Msb:FRACT_BITS];
    end
`else
    p_d = prod[Msb:FRACT_BITS];
`endif
  end

  // A new error from the MULT cycle overrides a simultaneous clear.
  always_comb begin
    err_d = err_clr ? 2'b00 : err_q;
    if (state_q == StMult) begin
      err_d = err_d | {unf_d, ovf_d};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= IdW'(NUM_REQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_p_q      <= '0;
      rsp_id_q     <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      err_q        <= 2'b00;
    end else begin
      if (grant) begin
        a_q          <= a_sel;
        b_q          <= b_sel;
        id_q         <= gnt_id;
        last_grant_q <= gnt_id;
      end
      if (state_q == StMult) begin
        rsp_p_q  <= p_d;
        rsp_id_q <= id_q;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
      end
      err_q <= err_d;
    end
  end

  assign rsp_p      = rsp_p_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_ovf    = ovf_q;
  assign rsp_unf    = unf_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_fixed_mult_arbiter.sv
// Directed self-checking bench for fixed_mult_arbiter (NUM_REQ=4, WIDTH=128, FRACT_BITS=8).
module tb_fixed_mult_arbiter;

  localparam int unsigned NumReq    = 4;
  localparam int unsigned Width     = 128;
  localparam int unsigned FractBits = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NumReq-1:0]         req_valid;
  logic [NumReq-1:0]         req_ready;
  logic [NumReq*Width-1:0]   req_a, req_b;
  logic                      rsp_valid, rsp_ready;
  logic [1:0]                rsp_id;
  logic [Width-1:0]          rsp_p;
  logic                      rsp_ovf, rsp_unf;
  logic [1:0]                err_sticky;
  logic                      err_clr;
  logic                      busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [Width-1:0] exp_p;
  logic [3:0]       exp_rdy;
  int unsigned      exp_id;

  always #5 clk = ~clk;

  fixed_mult_arbiter #(
    .NUM_REQ   (NumReq),
    .WIDTH     (Width),
    .FRACT_BITS(FractBits)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_ovf   (rsp_ovf),
    .rsp_unf   (rsp_unf),
    .err_sticky(err_sticky),
    .err_clr   (err_clr),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [Width-1:0] a, input logic [Width-1:0] b);
    req_a[i*Width +: Width] = a;
    req_b[i*Width +: Width] = b;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    err_clr   = 1'b0;

    // Reset state, including req_ready held low with requests pending
    tick();
    req_valid = 4'hF;
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_sticky, 0);
    check("rst_rsp_p", rsp_p, 0);
    check("rst_rsp_id", rsp_id, 0);
    req_valid = '0;
    rst       = 1'b0;
    tick();

    // 1.5 * 2.0 from requester 0, response at T+2
    set_req(0, 128'h180, 128'h200);
    req_valid = 4'b0001;
    #1;
    check("t1_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check("t1_mult_busy", busy, 1);
    check("t1_mult_ready", req_ready, 0);
    check("t1_mult_valid", rsp_valid, 0);
    tick();
    check("t1_valid", rsp_valid, 1);
    check("t1_p", rsp_p, 128'h300);
    check("t1_id", rsp_id, 0);
    check("t1_ovf", rsp_ovf, 0);
    check("t1_unf", rsp_unf, 0);
    tick();
    check("t1_drop_valid", rsp_valid, 0);
    check("t1_idle_busy", busy, 0);

    // -1.0 * 2.5 from requester 2, held in HOLD with rsp_ready low
    rsp_ready = 1'b0;
    set_req(2, -128'h100, 128'h280);
    req_valid = 4'b0100;
    #1;
    check("t2_grant", req_ready, 4'b0100);
    tick();
    req_valid = 4'b1011;
    tick();
    check("t2_id", rsp_id, 2);
    check("t2_ovf", rsp_ovf, 0);
    check("t2_unf", rsp_unf, 0);
    repeat (5) begin
      check("t2_hold_valid", rsp_valid, 1);
      check("t2_hold_p", rsp_p, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFD80);
      check("t2_hold_ready", req_ready, 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    check("t2_release_valid", rsp_valid, 0);
    check("t2_release_busy", busy, 0);

    // Positive overflow from requester 1
    set_req(1, 128'h40000000_00000000_00000000_00000000, 128'h400);
    req_valid = 4'b0010;
    #1;
    check("t3_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
`ifdef FIXED_MULT_SAT_EN
    exp_p = 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
`else
    exp_p = 128'h0;
`endif
    check("t3_p", rsp_p, exp_p);
    check("t3_ovf", rsp_ovf, 1);
    check("t3_unf", rsp_unf, 0);
    check("t3_id", rsp_id, 1);
    check("t3_err", err_sticky, 2'b01);
    tick();

    // Underflow from requester 3 with err_clr raised in the MULT cycle: set wins
    set_req(3, 128'hA0000000_00000000_00000000_00000000, 128'h400);
    req_valid = 4'b1000;
    #1;
    check("t4_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    err_clr   = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_err", err_sticky, 2'b10);
    check("t4_unf", rsp_unf, 1);
    check("t4_ovf", rsp_ovf, 0);
    check("t4_p", rsp_p, 128'h80000000_00000000_00000000_00000000);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_err_clr", err_sticky, 2'b00);

    // Reset pulsed in MULT discards the pending result
    set_req(2, 128'h100, 128'h100);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    check("t5_in_mult", busy, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", rsp_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_p", rsp_p, 0);
    check("t5_rst_id", rsp_id, 0);
    check("t5_rst_err", err_sticky, 0);
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      check("t5_no_rsp", rsp_valid, 0);
      check("t5_idle", busy, 0);
    end

    // All requesters active: grants 0,1,2,3,0, one every 3 cycles
    for (int i = 0; i < 4; i++) set_req(i, 128'(i + 1) << 8, 128'h100);
    req_valid = 4'hF;
    #1;
    for (int g = 0; g < 5; g++) begin
      exp_id  = g % 4;
      exp_rdy = 4'b0001 << exp_id;
      exp_p   = 128'(exp_id + 1) << 8;
      check("rr_grant", req_ready, exp_rdy);
      tick();
      check("rr_mult_ready", req_ready, 0);
      tick();
      check("rr_valid", rsp_valid, 1);
      check("rr_id", rsp_id, exp_id);
      check("rr_p", rsp_p, exp_p);
      tick();
    end
    req_valid = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
